// File: rtl/splio_n_if.sv
// Bus bundle for the serial LED output engine: frame request/data in,
// status and external shift-chain controls out.
interface splio_n_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic              en;
  logic [DATA_W-1:0] p_data;
  logic [DATA_W-1:0] led;
  logic              busy;
  logic              done;
  logic              led_clk;
  logic              led_sout;
  logic              led_clrn;
  logic              led_pen;

  modport master (
    output start, en, p_data,
    input  led, busy, done, led_clk, led_sout, led_clrn, led_pen
  );

  modport slave (
    input  start, en, p_data,
    output led, busy, done, led_clk, led_sout, led_clrn, led_pen
  );
endinterface

// File: rtl/splio_n.sv
// Serial-parallel LED output engine: latches a word on a rising start edge
// and shifts it out to an external shift-register chain.
module splio_n #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       clk,
  input logic       rst,
  splio_n_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                lclk_q, lclk_d;
  logic                sout_q, sout_d;
  logic                clrn_q, clrn_d;
  logic                pen_q, pen_d;
  logic                edge_s;
  logic [DATA_W-1:0]   shifted_s;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  assign edge_s    = bus.start & ~start_q;
  assign shifted_s = MSB_FIRST ? (shreg_q << 1'b1) : (shreg_q >> 1'b1);

  // Next-state and registered-output decode for the IDLE/SHIFT machine.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    shadow_d = shadow_q;
    bitcnt_d = bitcnt_q;
    phase_d  = phase_q;
    led_d    = led_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lclk_d   = lclk_q;
    sout_d   = sout_q;
    clrn_d   = 1'b1;
    pen_d    = pen_q;
    case (state_q)
      ST_IDLE: begin
        pen_d  = 1'b1;
        lclk_d = 1'b0;
        busy_d = 1'b0;
        if (edge_s && bus.en) begin
          state_d  = ST_SHIFT;
          shreg_d  = bus.p_data;
          shadow_d = bus.p_data;
          bitcnt_d = CNT_FULL;
          phase_d  = {PH_W{1'b0}};
          sout_d   = head_bit(bus.p_data);
          pen_d    = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        pen_d  = 1'b0;
        busy_d = 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = {PH_W{1'b0}};
          if (!lclk_q) begin
            lclk_d = 1'b1;
          end else begin
            // End of a high phase: the bit has been clocked out.
            lclk_d   = 1'b0;
            bitcnt_d = bitcnt_q - CNT_W'(1);
            if (bitcnt_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              sout_d  = 1'b0;
              led_d   = shadow_q;
              pen_d   = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              shreg_d = shifted_s;
              sout_d  = head_bit(shifted_s);
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b1;
      shreg_q  <= {DATA_W{1'b0}};
      shadow_q <= {DATA_W{1'b0}};
      bitcnt_q <= {CNT_W{1'b0}};
      phase_q  <= {PH_W{1'b0}};
      led_q    <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lclk_q   <= 1'b0;
      sout_q   <= 1'b0;
      clrn_q   <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      shreg_q  <= shreg_d;
      shadow_q <= shadow_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lclk_q   <= lclk_d;
      sout_q   <= sout_d;
      clrn_q   <= clrn_d;
      pen_q    <= pen_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.led_clk  = lclk_q;
  assign bus.led_sout = sout_q;
  assign bus.led_clrn = clrn_q;
  assign bus.led_pen  = pen_q;

endmodule
